instruction_fetch_memory: RTL

// Parametrised, pipelined instruction memory for the MIPS datapath; successor to the unclocked word ROM.

---
 rtl/instruction_fetch_memory.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_memory.sv
// Pipelined instruction memory: valid/ready fetch port, run-time load port, address-fault detection.
// Optional feature: define PARITY_CHECK_EN to store and check one even-parity bit per word.
module instruction_fetch_memory #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    DEPTH          = 128,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    READ_LATENCY   = 1,
    parameter bit                    BYTE_ADDRESSED = 1'b1,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD       = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_address,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  addr_fault,
    output logic                  parity_error,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_address,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        return BYTE_ADDRESSED ? (a >> 2) : a;
    endfunction

    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
        return (BYTE_ADDRESSED && (a[1:0] != 2'b00)) ||
               (word_index(a) >= ADDR_WIDTH'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] mem_index(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(word_index(a));
    endfunction

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [READ_LATENCY-1:0] valid_q, valid_d;
    logic [READ_LATENCY-1:0] fault_q, fault_d;
    logic [READ_LATENCY-1:0] perr_q, perr_d;
    logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   data_d [READ_LATENCY];

    logic                  stall;
    logic                  accept;
    logic                  req_fault;
    logic                  load_ok;
    logic [IDX_W-1:0]      rd_index;
    logic [IDX_W-1:0]      wr_index;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_perr;

    // A response sitting at the output that nobody takes freezes the whole pipe.
    assign stall     = valid_q[READ_LATENCY-1] & ~rsp_ready;
    assign req_ready = ~load_en & ~stall;
    assign accept    = req_valid & req_ready;

    assign req_fault = addr_bad(req_address);
    assign rd_index  = mem_index(req_address);
    assign rd_word   = mem_q[rd_index];
    assign wr_index  = mem_index(load_address);
    assign load_ok   = load_en & ~addr_bad(load_address);

    // Storage is not reset: program contents survive a pipeline reset.
    always_ff @(posedge clock) begin
        if (load_ok) begin
            mem_q[wr_index] <= load_data;
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_q [DEPTH];

    always_ff @(posedge clock) begin
        if (load_ok) begin
            par_q[wr_index] <= ^load_data;
        end
    end

    assign rd_perr = (^rd_word) ^ par_q[rd_index];
`else
    assign rd_perr = 1'b0;
`endif

    // Stage 0 captures the array read; later stages only delay it. Data moves only with a valid
    // beat so the output word holds its last value across empty slots.
    always_comb begin
        valid_d = valid_q;
        fault_d = fault_q;
        perr_d  = perr_q;
        data_d  = data_q;
        if (!stall) begin
            valid_d[0] = accept;
            if (accept) begin
                data_d[0]  = req_fault ? NOP_WORD : rd_word;
                fault_d[0] = req_fault;
                perr_d[0]  = ~req_fault & rd_perr;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i]  = data_q[i-1];
                    fault_d[i] = fault_q[i-1];
                    perr_d[i]  = perr_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            fault_q <= '0;
            perr_q  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= NOP_WORD;
            end
        end else begin
            valid_q <= valid_d;
            fault_q <= fault_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
        end
    end

    assign rsp_valid    = valid_q[READ_LATENCY-1];
    assign instruction  = data_q[READ_LATENCY-1];
    assign addr_fault   = fault_q[READ_LATENCY-1];
    assign parity_error = perr_q[READ_LATENCY-1];

endmodule
